// File: rtl/mssd_param.sv
// mssd_param: parametrised multi-port serial splitter/demultiplexer.
// Parses frames on serIn (start bit 0, PORT_W address bits, LEN_W length bits n,
// n payload bits, optional even-parity bit; every field MSB first) and presents
// each payload bit on out[activePort] in the same cycle it appears on serIn.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   serIn      - serial line, idles high
//   error      - one-cycle pulse, parity mismatch on the frame just completed
//   validOut   - high while a payload bit is on out
//   activePort - address of the current/last frame
//   out        - one-hot-masked payload bit (NPORT wide)
//   frameDone  - one-cycle pulse after the final bit of a frame
//   busy       - high whenever the parser is not idle
module mssd_param #(
    parameter int unsigned PORT_W    = 2,
    parameter int unsigned LEN_W     = 4,
    parameter int unsigned PARITY_EN = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     serIn,
    output logic                     error,
    output logic                     validOut,
    output logic [PORT_W-1:0]        activePort,
    output logic [(2**PORT_W)-1:0]   out,
    output logic                     frameDone,
    output logic                     busy
);

    localparam int unsigned SHW = (PORT_W > LEN_W) ? PORT_W : LEN_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PORT = 3'd1,
        LEN  = 3'd2,
        DATA = 3'd3,
        PAR  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [SHW-1:0]     shreg_q, shreg_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               par_q, par_d;
    logic [PORT_W-1:0]  ap_q, ap_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;

    logic [SHW-1:0]     shift_nxt;
    logic [LEN_W-1:0]   len_nxt;
    logic               par_nxt;

    // Next-state, field shifting and running parity
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        rem_d     = rem_q;
        par_d     = par_q;
        ap_d      = ap_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        // Truncating cast keeps the newest SHW bits, so the low bits hold the field
        shift_nxt = SHW'({shreg_q, serIn});
        len_nxt   = shift_nxt[LEN_W-1:0];
        par_nxt   = par_q ^ serIn;

        case (state_q)
            IDLE: begin
                if (!serIn) begin
                    state_d = PORT;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                end
            end
            PORT: begin
                shreg_d = shift_nxt;
                par_d   = par_nxt;
                if (cnt_q == SHW'(PORT_W - 1)) begin
                    ap_d    = shift_nxt[PORT_W-1:0];
                    cnt_d   = '0;
                    state_d = LEN;
                end else begin
                    cnt_d = cnt_q + SHW'(1);
                end
            end
            LEN: begin
                shreg_d = shift_nxt;
                par_d   = par_nxt;
                if (cnt_q == SHW'(LEN_W - 1)) begin
                    cnt_d = '0;
                    if (len_nxt != '0) begin
                        rem_d   = len_nxt;
                        state_d = DATA;
                    end else if (PARITY_EN != 0) begin
                        state_d = PAR;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + SHW'(1);
                end
            end
            DATA: begin
                par_d = par_nxt;
                rem_d = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) begin
                    if (PARITY_EN != 0) begin
                        state_d = PAR;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            PAR: begin
                // Even parity over address, length, payload and parity bit
                par_d   = par_nxt;
                state_d = IDLE;
                done_d  = 1'b1;
                err_d   = (PARITY_EN != 0) && par_nxt;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            rem_q   <= '0;
            par_q   <= 1'b0;
            ap_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            rem_q   <= rem_d;
            par_q   <= par_d;
            ap_q    <= ap_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Zero-latency payload routing
    always_comb begin
        out = '0;
        if (state_q == DATA) begin
            out[ap_q] = serIn;
        end
    end

    assign validOut   = (state_q == DATA);
    assign activePort = ap_q;
    assign frameDone  = done_q;
    assign error      = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mssd_param.sv
module tb_mssd_param;

    logic       clk;
    logic       rst;
    logic       ser;
    logic       error;
    logic       valid;
    logic [1:0] ap;
    logic [3:0] out;
    logic       done;
    logic       busy;

    logic       ser2;
    logic       error2;
    logic       valid2;
    logic [2:0] ap2;
    logic [7:0] out2;
    logic       done2;
    logic       busy2;

    int n_cmp  = 0;
    int n_fail = 0;

    mssd_param u_dut (
        .clk(clk), .rst(rst), .serIn(ser), .error(error), .validOut(valid),
        .activePort(ap), .out(out), .frameDone(done), .busy(busy)
    );

    mssd_param #(.PORT_W(3), .LEN_W(5), .PARITY_EN(0)) u_dut2 (
        .clk(clk), .rst(rst), .serIn(ser2), .error(error2), .validOut(valid2),
        .activePort(ap2), .out(out2), .frameDone(done2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ser;
        logic       busy;
        logic       valid;
        logic [3:0] out;
        logic       done;
        logic       err;
        logic [1:0] ap;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(input logic s, input logic b, input logic va,
                              input logic [3:0] o, input logic d, input logic e,
                              input logic [1:0] a);
        vec_t t;
        t.ser = s; t.busy = b; t.valid = va; t.out = o; t.done = d; t.err = e; t.ap = a;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        int  vcnt;
        logic s;
        logic ev;

        rst  = 1'b1;
        ser  = 1'b1;
        ser2 = 1'b1;
        #1 rst = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_error", 0, 32'(error), 32'd0);
        chk("rst_valid", 0, 32'(valid), 32'd0);
        chk("rst_ap",    0, 32'(ap),    32'd0);
        chk("rst_out",   0, 32'(out),   32'd0);
        chk("rst_done",  0, 32'(done),  32'd0);
        chk("rst_busy",  0, 32'(busy),  32'd0);
        chk("rst_busy2", 0, 32'(busy2), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        //   ser busy valid out    done err ap
        v(1, 0, 0, 4'b0000, 0, 0, 0);
        v(1, 0, 0, 4'b0000, 0, 0, 0);
        // Frame 1: port 2, n=3, payload 101, parity 1
        v(0, 0, 0, 4'b0000, 0, 0, 0);
        v(1, 1, 0, 4'b0000, 0, 0, 0);
        v(0, 1, 0, 4'b0000, 0, 0, 0);
        v(0, 1, 0, 4'b0000, 0, 0, 2);
        v(0, 1, 0, 4'b0000, 0, 0, 2);
        v(1, 1, 0, 4'b0000, 0, 0, 2);
        v(1, 1, 0, 4'b0000, 0, 0, 2);
        v(1, 1, 1, 4'b0100, 0, 0, 2);
        v(0, 1, 1, 4'b0000, 0, 0, 2);
        v(1, 1, 1, 4'b0100, 0, 0, 2);
        v(1, 1, 0, 4'b0000, 0, 0, 2);
        v(1, 0, 0, 4'b0000, 1, 0, 2);
        v(1, 0, 0, 4'b0000, 0, 0, 2);
        // Frame 2: same frame, parity bit 0 -> error
        v(0, 0, 0, 4'b0000, 0, 0, 2);
        v(1, 1, 0, 4'b0000, 0, 0, 2);
        v(0, 1, 0, 4'b0000, 0, 0, 2);
        v(0, 1, 0, 4'b0000, 0, 0, 2);
        v(0, 1, 0, 4'b0000, 0, 0, 2);
        v(1, 1, 0, 4'b0000, 0, 0, 2);
        v(1, 1, 0, 4'b0000, 0, 0, 2);
        v(1, 1, 1, 4'b0100, 0, 0, 2);
        v(0, 1, 1, 4'b0000, 0, 0, 2);
        v(1, 1, 1, 4'b0100, 0, 0, 2);
        v(0, 1, 0, 4'b0000, 0, 0, 2);
        v(1, 0, 0, 4'b0000, 1, 1, 2);
        v(1, 0, 0, 4'b0000, 0, 0, 2);
        // Frame 3: port 1, n=0, parity 1
        v(0, 0, 0, 4'b0000, 0, 0, 2);
        v(0, 1, 0, 4'b0000, 0, 0, 2);
        v(1, 1, 0, 4'b0000, 0, 0, 2);
        v(0, 1, 0, 4'b0000, 0, 0, 1);
        v(0, 1, 0, 4'b0000, 0, 0, 1);
        v(0, 1, 0, 4'b0000, 0, 0, 1);
        v(0, 1, 0, 4'b0000, 0, 0, 1);
        v(1, 1, 0, 4'b0000, 0, 0, 1);
        v(1, 0, 0, 4'b0000, 1, 0, 1);
        v(1, 0, 0, 4'b0000, 0, 0, 1);
        // Frame A: port 3, n=1, payload 0, parity 1
        v(0, 0, 0, 4'b0000, 0, 0, 1);
        v(1, 1, 0, 4'b0000, 0, 0, 1);
        v(1, 1, 0, 4'b0000, 0, 0, 1);
        v(0, 1, 0, 4'b0000, 0, 0, 3);
        v(0, 1, 0, 4'b0000, 0, 0, 3);
        v(0, 1, 0, 4'b0000, 0, 0, 3);
        v(1, 1, 0, 4'b0000, 0, 0, 3);
        v(0, 1, 1, 4'b0000, 0, 0, 3);
        v(1, 1, 0, 4'b0000, 0, 0, 3);
        // Frame B starts in A's frameDone cycle: port 0, n=2, payload 11, parity 1
        v(0, 0, 0, 4'b0000, 1, 0, 3);
        v(0, 1, 0, 4'b0000, 0, 0, 3);
        v(0, 1, 0, 4'b0000, 0, 0, 3);
        v(0, 1, 0, 4'b0000, 0, 0, 0);
        v(0, 1, 0, 4'b0000, 0, 0, 0);
        v(1, 1, 0, 4'b0000, 0, 0, 0);
        v(0, 1, 0, 4'b0000, 0, 0, 0);
        v(1, 1, 1, 4'b0001, 0, 0, 0);
        v(1, 1, 1, 4'b0001, 0, 0, 0);
        v(1, 1, 0, 4'b0000, 0, 0, 0);
        v(1, 0, 0, 4'b0000, 1, 0, 0);
        v(1, 0, 0, 4'b0000, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            ser = vecs[i].ser;
            #1;
            chk("busy",  i, 32'(busy),  32'(vecs[i].busy));
            chk("valid", i, 32'(valid), 32'(vecs[i].valid));
            chk("out",   i, 32'(out),   32'(vecs[i].out));
            chk("done",  i, 32'(done),  32'(vecs[i].done));
            chk("error", i, 32'(error), 32'(vecs[i].err));
            chk("ap",    i, 32'(ap),    32'(vecs[i].ap));
        end

        // Reset during the second payload bit aborts the frame silently
        begin
            logic [8:0] bits;
            bits = 9'b010001110;
            for (int i = 0; i < 9; i++) begin
                @(negedge clk);
                ser = bits[8 - i];
            end
            #1;
            chk("mid_valid_pre", 0, 32'(valid), 32'd1);
            #2 rst = 1'b0;
            #1;
            chk("mid_busy",  0, 32'(busy),  32'd0);
            chk("mid_valid", 0, 32'(valid), 32'd0);
            chk("mid_out",   0, 32'(out),   32'd0);
            chk("mid_ap",    0, 32'(ap),    32'd0);
            chk("mid_done",  0, 32'(done),  32'd0);
            chk("mid_error", 0, 32'(error), 32'd0);
            @(negedge clk);
            ser = 1'b1;
            rst = 1'b1;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                #1;
                chk("post_busy", i, 32'(busy), 32'd0);
                chk("post_done", i, 32'(done), 32'd0);
            end
        end

        // PORT_W=3, LEN_W=5, no parity: port 6, n=31
        vcnt = 0;
        for (int c = 0; c < 44; c++) begin
            if (c == 0)                 s = 1'b0;
            else if (c <= 2)            s = 1'b1;
            else if (c == 3)            s = 1'b0;
            else if (c <= 8)            s = 1'b1;
            else if (c <= 39)           s = ((c - 9) % 3) == 0;
            else                        s = 1'b1;
            ev = (c >= 9) && (c <= 39);
            @(negedge clk);
            ser2 = s;
            #1;
            if (valid2) vcnt++;
            chk("p2_valid", c, 32'(valid2), 32'(ev));
            chk("p2_out",   c, 32'(out2),   ev ? (32'(s) << 6) : 32'd0);
            chk("p2_done",  c, 32'(done2),  32'(c == 40));
            chk("p2_error", c, 32'(error2), 32'd0);
            chk("p2_busy",  c, 32'(busy2),  32'((c >= 1) && (c <= 39)));
            chk("p2_ap",    c, 32'(ap2),    (c >= 4) ? 32'd6 : 32'd0);
        end
        chk("p2_valid_cycles", 0, 32'(vcnt), 32'd31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
